// File: rtl/matmul_operand_feeder.sv
// Operand feeder for an N x N systolic matrix multiplier.
// Holds the A and B operands in register buffers, then streams them as
// diagonally skewed wavefronts: PE row i receives A[i][t-i] and PE column j
// receives B[t-j][j] at beat t, for K+N-1 consecutive beats.
module matmul_operand_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic                      wr_sel_i,
  input  logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0] wr_row_i,
  input  logic [BUS_WIDTH-1:0]      wr_data_i,
  input  logic                      start_i,
  input  logic [$clog2(BUS_WIDTH/DATA_WIDTH):0]   k_i,
  output logic [BUS_WIDTH-1:0]      a_o,
  output logic [BUS_WIDTH-1:0]      b_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int N     = BUS_WIDTH / DATA_WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam int K_W   = $clog2(N) + 1;
  localparam int T_W   = $clog2(2 * N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic [K_W-1:0] k_q, k_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_mem_q, a_mem_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] b_mem_q, b_mem_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic last_beat_s;
  logic k_legal_s;
  int   rel_s;

  // Detect the final beat of the current stream and legality of a requested K.
  always_comb begin
    last_beat_s = (int'(t_q) == (int'(k_q) + N - 2));
    k_legal_s   = (k_i != '0) && (k_i <= K_W'(N));
  end

  // Next-state logic: FSM transitions, operand buffer writes, command rejection.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The write lands in the _d buffers, so a same-cycle start sees the new row.
        if (wr_en_i) begin
          if (wr_sel_i) begin
            b_mem_d[wr_row_i] = wr_data_i;
          end else begin
            a_mem_d[wr_row_i] = wr_data_i;
          end
        end else begin
          a_mem_d = a_mem_q;
        end
        if (start_i) begin
          if (k_legal_s) begin
            state_d = ST_STREAM;
            t_d     = '0;
            k_d     = k_i;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        err_d = wr_en_i | start_i;
        if (last_beat_s) begin
          state_d = ST_DONE;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_DONE: begin
        err_d   = wr_en_i | start_i;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Beat data for the next cycle: skewed diagonal selection from the buffers.
  always_comb begin
    a_d   = '0;
    b_d   = '0;
    rel_s = 0;
    for (int i = 0; i < N; i++) begin
      rel_s = int'(t_d) - i;
      if ((state_d == ST_STREAM) && (rel_s >= 0) && (rel_s < int'(k_d))) begin
        a_d[i*DATA_WIDTH +: DATA_WIDTH] = a_mem_d[i][rel_s[IDX_W-1:0]];
        b_d[i*DATA_WIDTH +: DATA_WIDTH] = b_mem_d[rel_s[IDX_W-1:0]][i];
      end else begin
        a_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        b_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Status flags follow the next state so they line up with the registered beat data.
  always_comb begin
    valid_d = (state_d == ST_STREAM);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, buffers and all outputs; reset clears everything including the operands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      k_q     <= '0;
      a_mem_q <= '0;
      b_mem_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Scoreboard bench for matmul_operand_feeder: stimulus pushes expected beats,
// a negedge monitor pops and compares whenever valid_o is high.
module tb_matmul_operand_feeder;

  localparam int DW = 16;
  localparam int BW = 64;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wr_en_i = 1'b0;
  logic          wr_sel_i = 1'b0;
  logic [1:0]    wr_row_i = 2'd0;
  logic [BW-1:0] wr_data_i = '0;
  logic          start_i = 1'b0;
  logic [2:0]    k_i = 3'd0;
  logic [BW-1:0] a_o, b_o;
  logic          valid_o, busy_o, done_o, err_o;

  matmul_operand_feeder #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_row_i(wr_row_i), .wr_data_i(wr_data_i), .start_i(start_i), .k_i(k_i),
    .a_o(a_o), .b_o(b_o), .valid_o(valid_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0]   m_a [N][N];
  logic [DW-1:0]   m_b [N][N];
  logic [2*BW-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int beat_idx = 0;
  bit id_check = 1'b0;
  logic [BW-1:0] id_beat3_a = {16'd13, 16'd10, 16'd7, 16'd4};

  task automatic check(input string name, input logic [2*BW-1:0] act, input logic [2*BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*BW-1:0] model_beat(input int t, input int k);
    logic [BW-1:0] ea, eb;
    ea = '0;
    eb = '0;
    for (int i = 0; i < N; i++) begin
      if ((t - i >= 0) && (t - i < k)) begin
        ea[i*DW +: DW] = m_a[i][t-i];
        eb[i*DW +: DW] = m_b[t-i][i];
      end
    end
    return {ea, eb};
  endfunction

  task automatic push_run(input int k);
    for (int t = 0; t < k + N - 1; t++) exp_q.push_back(model_beat(t, k));
  endtask

  task automatic model_write(input bit sel, input int r, input logic [BW-1:0] d);
    for (int c = 0; c < N; c++) begin
      if (sel) m_b[r][c] = d[c*DW +: DW];
      else     m_a[r][c] = d[c*DW +: DW];
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_a[r][c] = '0;
        m_b[r][c] = '0;
      end
  endtask

  // Called at posedge+1 while IDLE; returns at posedge+1.
  task automatic write_row(input bit sel, input int r, input logic [BW-1:0] d);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_row_i = 2'(r); wr_data_i = d;
    model_write(sel, r, d);
    @(posedge clk); #1;
    wr_en_i = 1'b0; wr_data_i = '0;
  endtask

  task automatic start_run(input int k, input bit ok);
    start_i = 1'b1; k_i = 3'(k);
    if (ok) push_run(k);
    @(posedge clk); #1;
    start_i = 1'b0; k_i = 3'd0;
  endtask

  // Counts negedges from the one after start until done_o; returns at posedge+1 after DONE.
  task automatic wait_done(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int c = 1; c <= 30 && !found; c++) begin
      @(negedge clk);
      if (done_o) begin
        found = 1'b1;
        n = c;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done_o within 30 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic load_identity();
    for (int r = 0; r < N; r++) begin
      write_row(1'b0, r, {16'(4 + 4*r), 16'(3 + 4*r), 16'(2 + 4*r), 16'(1 + 4*r)});
      write_row(1'b1, r, 64'd1 << (r * DW));
    end
  endtask

  // Monitor: scoreboard pop on every valid beat plus pulse counters.
  initial begin
    logic [2*BW-1:0] e;
    forever begin
      @(negedge clk);
      if (err_o) err_cnt++;
      if (done_o) done_cnt++;
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got a=%h b=%h with no expected beat", a_o, b_o);
        end else begin
          e = exp_q.pop_front();
          check("beat", {a_o, b_o}, e);
        end
        if (id_check && beat_idx == 3) check("identity_beat3_a", {64'd0, a_o}, {64'd0, id_beat3_a});
        beat_idx++;
      end else begin
        beat_idx = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e0;
    model_clear();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {a_o, b_o}, '0);
    check("reset_flags", {124'd0, valid_o, busy_o, done_o, err_o}, '0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Identity: 7 beats, done at cycle 8, beat 3 skew check
    load_identity();
    id_check = 1'b1;
    start_run(4, 1'b1);
    wait_done(n);
    id_check = 1'b0;
    check("identity_done_cycle", 128'(n), 128'd8);
    check("identity_all_beats", 128'(exp_q.size()), 128'd0);
    @(negedge clk);
    check("idle_after_done", {126'd0, busy_o, done_o}, '0);
    @(posedge clk); #1;

    // Short K
    start_run(1, 1'b1);
    wait_done(n);
    check("shortk_done_cycle", 128'(n), 128'd5);

    // Illegal K values
    e0 = err_cnt;
    start_run(0, 1'b0);
    @(negedge clk);
    check("k0_err_busy", {126'd0, err_o, busy_o}, {126'd0, 2'b10});
    @(posedge clk); #1;
    start_run(5, 1'b0);
    @(negedge clk);
    check("k5_err_busy", {126'd0, err_o, busy_o}, {126'd0, 2'b10});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("illegal_err_count", 128'(err_cnt - e0), 128'd2);

    // Busy: write + start together mid-stream
    e0 = err_cnt;
    start_run(4, 1'b1);
    @(negedge clk);
    check("busy_high", {127'd0, busy_o}, {127'd0, 1'b1});
    @(posedge clk); #1;
    wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_row_i = 2'd0; wr_data_i = '1;
    start_i = 1'b1; k_i = 3'd4;
    @(posedge clk); #1;
    wr_en_i = 1'b0; wr_data_i = '0; start_i = 1'b0; k_i = 3'd0;
    wait_done(n);
    check("busy_single_err", 128'(err_cnt - e0), 128'd1);

    // A[0] unchanged: rerun with the unchanged model
    start_run(4, 1'b1);
    wait_done(n);
    check("a0_unchanged_run", 128'(exp_q.size()), 128'd0);

    // Reset mid-stream at beat 2
    start_run(4, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    #1 rst_ni = 1'b0;
    #1;
    check("midreset_outputs", {a_o, b_o}, '0);
    check("midreset_flags", {124'd0, valid_o, busy_o, done_o, err_o}, '0);
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    start_run(4, 1'b1);
    wait_done(n);
    check("zero_stream_done_cycle", 128'(n), 128'd8);

    // Back-to-back runs
    load_identity();
    start_run(4, 1'b1);
    wait_done(n);
    start_run(4, 1'b1);
    wait_done(n);
    check("b2b_done_cycle", 128'(n), 128'd8);

    // Same-cycle write + start in IDLE
    wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_row_i = 2'd0;
    wr_data_i = {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
    model_write(1'b0, 0, wr_data_i);
    start_i = 1'b1; k_i = 3'd4;
    push_run(4);
    @(posedge clk); #1;
    wr_en_i = 1'b0; wr_data_i = '0; start_i = 1'b0; k_i = 3'd0;
    wait_done(n);
    check("samecycle_done_cycle", 128'(n), 128'd8);

    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    check("done_pulse_count", 128'(done_cnt), 128'd8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_operand_feeder.md
MATMUL_OPERAND_FEEDER -- requirements
Module: matmul_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one matrix element (signed).
REQ-002 SHALL have parameter BUS_WIDTH, default 64, width of one packed matrix row.
REQ-003 SHALL derive the local constant N = BUS_WIDTH/DATA_WIDTH (4 at defaults), which is the matrix dimension and the systolic array edge.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en_i, input, 1, writes one operand row this cycle.
REQ-007 SHALL have port wr_sel_i, input, 1, selects the target matrix: 0 = A, 1 = B.
REQ-008 SHALL have port wr_row_i, input, $clog2(N), selects the row index.
REQ-009 SHALL have port wr_data_i, input, BUS_WIDTH, carries the row; element c sits at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port start_i, input, 1, a one-cycle pulse that begins streaming.
REQ-011 SHALL have port k_i, input, $clog2(N)+1, the reduction length K, sampled with start_i.
REQ-012 SHALL have port a_o, output, N*DATA_WIDTH, the skewed A element entering PE row i at slice i.
REQ-013 SHALL have port b_o, output, N*DATA_WIDTH, the skewed B element entering PE column j at slice j.
REQ-014 SHALL have port valid_o, output, 1, which is high while a_o and b_o carry a stream beat.
REQ-015 SHALL have port busy_o, output, 1, which is high in STREAM and DONE.
REQ-016 SHALL have port done_o, output, 1, a one-cycle pulse when the stream completes.
REQ-017 SHALL have port err_o, output, 1, a one-cycle pulse when a command is rejected.

Function
REQ-018 SHALL hold two N x N element buffers, A and B, in registers.
REQ-019 SHALL, in IDLE, write wr_data_i into the selected buffer row on the next edge when wr_en_i=1.
REQ-020 SHALL implement states IDLE, STREAM and DONE.
- IDLE -> STREAM: start_i=1 and 1 <= k_i <= N.
- STREAM -> DONE: after the last beat.
- DONE -> IDLE: unconditionally after 1 cycle.
REQ-021 SHALL, in IDLE, reject start_i=1 with k_i=0 or k_i>N by pulsing err_o the next cycle and staying in IDLE.
REQ-022 SHALL register K and clear beat counter t to 0 on accepted start; the first beat (valid_o=1, t=0) appears the cycle after start_i.
REQ-023 SHALL produce exactly K+N-1 beats on consecutive cycles; t increments by one each beat with no stalls.
REQ-024 SHALL, at beat t, drive a_o slice i = A[i][t-i] when 0 <= t-i < K, else 0.
REQ-025 SHALL, at beat t, drive b_o slice j = B[t-j][j] when 0 <= t-j < K, else 0.
REQ-026 SHALL register a_o, b_o and valid_o; they are 0 whenever valid_o=0.
REQ-027 SHALL pulse done_o in the cycle after the last beat (DONE state); busy_o drops the following cycle.
REQ-028 SHALL, while busy_o=1, ignore wr_en_i (buffers unchanged) and pulse err_o the next cycle for that write.
REQ-029 SHALL, while busy_o=1, ignore start_i and pulse err_o the next cycle; wr_en_i and start_i together while busy give a single err pulse.
REQ-030 SHALL, in IDLE, give the write priority when wr_en_i and start_i are both 1 in the same cycle; the stream then uses the new row.
REQ-031 SHALL accept a new start_i in the cycle after DONE (back-to-back runs).

Reset
REQ-032 SHALL, on rst_ni=0 at any time including mid-stream, immediately drive state = IDLE, t = 0, K = 0, all A/B entries = 0, a_o = b_o = 0, valid_o = busy_o = done_o = err_o = 0.
REQ-033 SHALL leave reset in IDLE with no pending start, write or error.

Verification
REQ-034 Bench SHALL cover the following directed scenarios:
- Identity: load A = rows {1,2,3,4}+4r and B = identity, then start k=4. Expect 7 beats, done_o at cycle 8 after start, and beat 3 with a_o = {A[3][0], A[2][1], A[1][2], A[0][3]}.
- Short K: start k=1. Expect 4 beats; beat t has only slice i=t nonzero, equal to A[t][0] and B[0][t].
- Illegal: start k=0, then k=5. Each gives an err_o pulse, and busy_o stays 0.
- Busy: while streaming, assert wr_en_i to A row 0 and start_i together. Expect one err_o pulse and an unchanged stream, and A[0] unchanged after done.
- Reset mid-operation: assert rst_ni=0 at beat 2. Expect all outputs 0 asynchronously; after release, a start with k=4 streams all zeros.
- Back-to-back and same-cycle: a start in the cycle after done_o is accepted. A write plus start in IDLE streams the newly written row.
